// File: rtl/calc_mul_sequencer.sv
// calc_mul_sequencer
// Operand-entry and result sequencer for the 2-bit multiplier calculator.
// Captures operand A and then operand B from the switches on successive Enter
// presses. It presents the operands to the external multiplier, latches the
// product, and chooses what the 7-segment decoder shows: the live operand
// (blinking) or the held result.
module calc_mul_sequencer #(
    parameter int BLINK_CYCLES = 25000000,
    parameter int SHOW_CYCLES  = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [3:0] product,
    output logic [1:0] mul_a,
    output logic [1:0] mul_b,
    output logic [3:0] disp_val,
    output logic       disp_blank,
    output logic [1:0] state_led,
    output logic       result_valid
);

    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int SHOW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        CALC  = 2'b10,
        SHOW  = 2'b11
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mul_a;
    logic [1:0]          r_mul_b;
    logic [3:0]          r_result;
    logic [3:0]          r_disp_val;
    logic                r_disp_blank;
    logic                r_result_valid;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;
    logic [SHOW_W-1:0]   r_show_cnt;
    logic                r_enter_q;
    // Set during reset so an Enter held through reset is not seen as a press
    // on the first cycle after release.
    logic                r_rst_q;
    logic                w_enter_evt;

    assign w_enter_evt = btn_enter & ~r_enter_q & ~r_rst_q;

    // Sequencer FSM: operand capture, product latch, display selection, blink and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= GET_A;
            r_mul_a        <= 2'b00;
            r_mul_b        <= 2'b00;
            r_result       <= 4'd0;
            r_disp_val     <= 4'd0;
            r_disp_blank   <= 1'b0;
            r_result_valid <= 1'b0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b0;
            r_show_cnt     <= '0;
            r_enter_q      <= 1'b0;
            r_rst_q        <= 1'b1;
        end else begin
            r_enter_q <= btn_enter;
            r_rst_q   <= 1'b0;
            if (btn_clear) begin
                // Clear wins over any Enter edge in the same cycle
                r_state        <= GET_A;
                r_mul_a        <= 2'b00;
                r_mul_b        <= 2'b00;
                r_result       <= 4'd0;
                r_result_valid <= 1'b0;
                r_disp_val     <= {2'b00, sw};
                r_disp_blank   <= 1'b0;
                r_blink_cnt    <= '0;
                r_blink_phase  <= 1'b0;
                r_show_cnt     <= '0;
            end else begin
                case (r_state)
                    GET_A, GET_B: begin
                        r_disp_val <= {2'b00, sw};
                        if (w_enter_evt) begin
                            if (r_state == GET_A) begin
                                r_mul_a <= sw;
                                r_state <= GET_B;
                            end else begin
                                r_mul_b <= sw;
                                r_state <= CALC;
                            end
                            // Each new operand starts with a visible half-period
                            r_blink_cnt   <= '0;
                            r_blink_phase <= 1'b0;
                            r_disp_blank  <= 1'b0;
                        end else if (r_blink_cnt == BLINK_LAST) begin
                            r_blink_cnt   <= '0;
                            r_blink_phase <= ~r_blink_phase;
                            r_disp_blank  <= ~r_blink_phase;
                        end else begin
                            r_blink_cnt  <= r_blink_cnt + BLINK_W'(1);
                            r_disp_blank <= r_blink_phase;
                        end
                    end
                    CALC: begin
                        // Operands have been stable for this cycle; take the product
                        r_result       <= product;
                        r_disp_val     <= product;
                        r_disp_blank   <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_show_cnt     <= '0;
                        r_state        <= SHOW;
                    end
                    SHOW: begin
                        if (w_enter_evt || (r_show_cnt == SHOW_LAST)) begin
                            r_state        <= GET_A;
                            r_result_valid <= 1'b0;
                            r_disp_val     <= {2'b00, sw};
                            r_disp_blank   <= 1'b0;
                            r_blink_cnt    <= '0;
                            r_blink_phase  <= 1'b0;
                            r_show_cnt     <= '0;
                        end else begin
                            r_disp_val <= r_result;
                            r_show_cnt <= r_show_cnt + SHOW_W'(1);
                        end
                    end
                    default: r_state <= GET_A;
                endcase
            end
        end
    end

    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign disp_val     = r_disp_val;
    assign disp_blank   = r_disp_blank;
    assign state_led    = r_state;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_calc_mul_sequencer.sv
// Testbench for calc_mul_sequencer: directed scenarios followed by random
// button/switch activity, compared cycle by cycle with a behavioural model.
module tb_calc_mul_sequencer;

    localparam int BLINK = 4;
    localparam int SHOWN = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] product;
    logic [1:0] mul_a;
    logic [1:0] mul_b;
    logic [3:0] disp_val;
    logic       disp_blank;
    logic [1:0] state_led;
    logic       result_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: what the outputs should be after each edge
    int m_state;
    int m_a, m_b, m_res, m_val, m_blank, m_valid;
    int m_since;       // cycles spent since entering current GET/SHOW phase
    int m_prev_enter;
    int m_after_rst;

    calc_mul_sequencer #(
        .BLINK_CYCLES(BLINK),
        .SHOW_CYCLES (SHOWN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn_enter   (btn_enter),
        .btn_clear   (btn_clear),
        .product     (product),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .disp_val    (disp_val),
        .disp_blank  (disp_blank),
        .state_led   (state_led),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational 2x2 multiplier
    assign product = {2'b00, mul_a} * {2'b00, mul_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: advance expected outputs by one clock edge
    task automatic model_step();
        int evt;
        evt = (btn_enter && !m_prev_enter && !m_after_rst) ? 1 : 0;
        if (rst) begin
            m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_val = 0;
            m_blank = 0; m_valid = 0; m_since = 0;
            m_prev_enter = 0; m_after_rst = 1;
            return;
        end
        m_after_rst  = 0;
        m_prev_enter = btn_enter;
        if (btn_clear) begin
            m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_valid = 0;
            m_val = sw; m_blank = 0; m_since = 0;
            return;
        end
        case (m_state)
            0, 1: begin
                m_val = sw;
                if (evt) begin
                    if (m_state == 0) m_a = sw; else m_b = sw;
                    m_state = m_state + 1;
                    m_since = 0;
                    m_blank = 0;
                end else begin
                    m_since++;
                    m_blank = (m_since / BLINK) % 2;
                end
            end
            2: begin
                m_res = m_a * m_b;
                m_val = m_res;
                m_blank = 0;
                m_valid = 1;
                m_since = 0;
                m_state = 3;
            end
            default: begin
                if (evt || m_since == SHOWN - 1) begin
                    m_state = 0; m_valid = 0; m_val = sw; m_blank = 0; m_since = 0;
                end else begin
                    m_since++;
                    m_val = m_res;
                end
            end
        endcase
    endtask

    task automatic cyc(input logic r, input logic e, input logic c, input logic [1:0] s);
        rst = r; btn_enter = e; btn_clear = c; sw = s;
        @(posedge clk);
        model_step();
        #1;
        check("state",  state_led,    m_state);
        check("mul_a",  mul_a,        m_a);
        check("mul_b",  mul_b,        m_b);
        check("disp",   disp_val,     m_val);
        check("blank",  disp_blank,   m_blank);
        check("valid",  result_valid, m_valid);
    endtask

    task automatic press(input logic [1:0] s);
        cyc(0, 1, 0, s);
        cyc(0, 0, 0, s);
    endtask

    initial begin
        logic e;
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_val = 0;
        m_blank = 0; m_valid = 0; m_since = 0; m_prev_enter = 0; m_after_rst = 1;

        // Reset with Enter held, then release reset while Enter stays high
        cyc(1, 1, 0, 2'b11);
        cyc(1, 1, 0, 2'b11);
        check("rst_state", state_led, 0);
        check("rst_disp", disp_val, 0);
        repeat (3) cyc(0, 1, 0, 2'b11);
        check("no_adv_after_rst", state_led, 0);
        cyc(0, 0, 0, 2'b11);

        // 3 * 2, then let SHOW time out
        press(2'b11);
        check("a_captured", mul_a, 3);
        press(2'b10);
        check("show_val_6", disp_val, 6);
        check("show_valid", result_valid, 1);
        repeat (SHOWN + 4) cyc(0, 0, 0, 2'b01);
        check("timeout_state", state_led, 0);

        // Blink pattern while idle in GET_A
        repeat (14) cyc(0, 0, 0, 2'b10);

        // 3 * 3, leave SHOW with Enter
        press(2'b11);
        press(2'b11);
        check("show_val_9", disp_val, 9);
        repeat (3) cyc(0, 0, 0, 2'b00);
        press(2'b00);
        check("enter_leaves_show", state_led, 0);

        // Held Enter for 10 cycles gives exactly one advance
        repeat (10) cyc(0, 1, 0, 2'b01);
        check("held_enter", state_led, 1);
        cyc(0, 0, 0, 2'b01);

        // Clear and a fresh Enter edge together in GET_B
        cyc(0, 1, 1, 2'b10);
        check("clear_prio", state_led, 0);
        cyc(0, 0, 0, 2'b10);

        // Reset in the middle of SHOW, then a new calculation
        press(2'b11);
        press(2'b10);
        cyc(0, 0, 0, 2'b10);
        cyc(1, 0, 0, 2'b10);
        check("rst_mid_show_valid", result_valid, 0);
        cyc(0, 0, 0, 2'b01);
        press(2'b01);
        press(2'b10);
        check("post_rst_product", disp_val, 2);

        // Random activity
        e = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) e = ~e;
            cyc(($urandom_range(0, 299) == 0), e,
                ($urandom_range(0, 79) == 0), 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
